// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants, scan-position type and helpers for the sync generator
// and the sprite stages that bounds-check against H_DISPLAY/V_DISPLAY.
package vga_sync_gen_pkg;

  localparam int unsigned CNT_W       = 10;
  localparam int unsigned FRAME_CNT_W = 8;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_RETRACE_DEF = 96;
  localparam int unsigned H_BACK_DEF    = 48;

  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_RETRACE_DEF = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned PIX_DIV_DEF = 2;

  // Total line or frame length from its display/front/retrace/back components.
  function automatic int unsigned scan_total(input int unsigned disp, input int unsigned front,
                                             input int unsigned retrace, input int unsigned back);
    return disp + front + retrace + back;
  endfunction

  localparam int unsigned H_TOTAL_DEF =
    scan_total(H_DISPLAY_DEF, H_FRONT_DEF, H_RETRACE_DEF, H_BACK_DEF);
  localparam int unsigned V_TOTAL_DEF =
    scan_total(V_DISPLAY_DEF, V_FRONT_DEF, V_RETRACE_DEF, V_BACK_DEF);

  typedef struct packed {
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } scan_pos_t;

endpackage

// File: rtl/vga_sync_gen_pixel_div.sv
// Pixel-clock divider: mod-PIX_DIV counter whose terminal count is the one-clk pixel tick.
module vga_pixel_div #(
  parameter int unsigned PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic o_p_tick
);

  localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  if (PIX_DIV == 1) begin : g_no_div
    // Every clock is a pixel clock, including while reset is held.
    assign o_p_tick = 1'b1;
  end else begin : g_div
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_div_cnt <= '0;
      end else if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end

    assign o_p_tick = (r_div_cnt == DIV_LAST);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan timing: pixel tick, h/v scan counters, registered syncs, video_on and refr_tick.
// Build option VGA_FRAME_CNT_EN adds an 8-bit frame counter output (frame_cnt).
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_DISPLAY = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_RETRACE = H_RETRACE_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_DISPLAY = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_RETRACE = V_RETRACE_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned PIX_DIV   = PIX_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             refr_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = scan_total(H_DISPLAY, H_FRONT, H_RETRACE, H_BACK);
  localparam int unsigned V_TOTAL = scan_total(V_DISPLAY, V_FRONT, V_RETRACE, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
  localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISPLAY + V_FRONT + V_RETRACE - 1);
  localparam logic [CNT_W-1:0] REFR_LINE  = CNT_W'(V_DISPLAY + 1);

  logic      w_p_tick;
  logic      w_h_end;
  logic      w_v_end;
  logic      w_refr_tick;
  scan_pos_t w_pos_next;
  scan_pos_t r_pos;
  logic      r_hsync;
  logic      r_vsync;

  vga_pixel_div #(
    .PIX_DIV (PIX_DIV)
  ) u_pixel_div (
    .clk      (clk),
    .reset    (reset),
    .o_p_tick (w_p_tick)
  );

  assign w_h_end = (r_pos.x == H_LAST);
  assign w_v_end = (r_pos.y == V_LAST);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_pos_next = r_pos;
    if (w_p_tick) begin
      if (w_h_end) begin
        w_pos_next.x = '0;
        w_pos_next.y = w_v_end ? '0 : r_pos.y + CNT_W'(1);
      end else begin
        w_pos_next.x = r_pos.x + CNT_W'(1);
      end
    end
  end

  // Syncs decode the next position so they change on the same edge as pix_x/pix_y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_pos   <= w_pos_next;
      r_hsync <= ~((w_pos_next.x >= HS_FIRST) && (w_pos_next.x <= HS_LAST));
      r_vsync <= ~((w_pos_next.y >= VS_FIRST) && (w_pos_next.y <= VS_LAST));
    end
  end

  assign w_refr_tick = w_p_tick && (r_pos.x == '0) && (r_pos.y == REFR_LINE);

  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign pix_x     = r_pos.x;
  assign pix_y     = r_pos.y;
  assign p_tick    = w_p_tick;
  assign refr_tick = w_refr_tick;
  assign video_on  = (r_pos.x < H_VIS) && (r_pos.y < V_VIS);

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else if (w_refr_tick) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing line table plus two reduced-timing instances
// (PIX_DIV 2 and 1) compared every clock against an absolute-time reference model.
module tb_vga_sync_gen;

  typedef struct packed {
    int hd; int hf; int hr; int hb;
    int vd; int vf; int vr; int vb;
    int d;
  } cfg_t;

  typedef struct packed {
    int x; int y; int hs; int vs; int vo; int pt; int rt;
  } vga_t;

  typedef struct {
    int k; int x; int y; int hs; int vs; int vo; int pt;
  } vec_t;

  localparam cfg_t CFG_DEF = '{hd: 640, hf: 16, hr: 96, hb: 48,
                               vd: 480, vf: 10, vr: 2, vb: 33, d: 2};
  localparam cfg_t CFG_SM  = '{hd: 4, hf: 1, hr: 2, hb: 1,
                               vd: 3, vf: 1, vr: 1, vb: 2, d: 2};
  localparam cfg_t CFG_D1  = '{hd: 4, hf: 1, hr: 2, hb: 1,
                               vd: 3, vf: 1, vr: 1, vb: 2, d: 1};
  localparam int SM_FRAME_CLKS = 8 * 7 * 2;

  logic clk;
  logic rst_n;

  logic       def_hsync, def_vsync, def_video_on, def_p_tick, def_refr_tick;
  logic [9:0] def_pix_x, def_pix_y;
  logic       sm_hsync, sm_vsync, sm_video_on, sm_p_tick, sm_refr_tick;
  logic [9:0] sm_pix_x, sm_pix_y;
  logic       d1_hsync, d1_vsync, d1_video_on, d1_p_tick, d1_refr_tick;
  logic [9:0] d1_pix_x, d1_pix_y;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] def_frame_cnt, sm_frame_cnt, d1_frame_cnt;
`endif

  vga_sync_gen u_def (
    .clk (clk), .reset (rst_n),
    .hsync (def_hsync), .vsync (def_vsync), .video_on (def_video_on),
    .p_tick (def_p_tick), .pix_x (def_pix_x), .pix_y (def_pix_y),
    .refr_tick (def_refr_tick)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt (def_frame_cnt)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_RETRACE (2), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_RETRACE (1), .V_BACK (2),
    .PIX_DIV (2)
  ) u_sm (
    .clk (clk), .reset (rst_n),
    .hsync (sm_hsync), .vsync (sm_vsync), .video_on (sm_video_on),
    .p_tick (sm_p_tick), .pix_x (sm_pix_x), .pix_y (sm_pix_y),
    .refr_tick (sm_refr_tick)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt (sm_frame_cnt)
`endif
  );

  vga_sync_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_RETRACE (2), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_RETRACE (1), .V_BACK (2),
    .PIX_DIV (1)
  ) u_d1 (
    .clk (clk), .reset (rst_n),
    .hsync (d1_hsync), .vsync (d1_vsync), .video_on (d1_video_on),
    .p_tick (d1_p_tick), .pix_x (d1_pix_x), .pix_y (d1_pix_y),
    .refr_tick (d1_refr_tick)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt (d1_frame_cnt)
`endif
  );

  vga_t o_def, o_sm, o_d1;

  always_comb begin
    o_def = '{x: int'(def_pix_x), y: int'(def_pix_y), hs: int'(def_hsync), vs: int'(def_vsync),
              vo: int'(def_video_on), pt: int'(def_p_tick), rt: int'(def_refr_tick)};
    o_sm  = '{x: int'(sm_pix_x), y: int'(sm_pix_y), hs: int'(sm_hsync), vs: int'(sm_vsync),
              vo: int'(sm_video_on), pt: int'(sm_p_tick), rt: int'(sm_refr_tick)};
    o_d1  = '{x: int'(d1_pix_x), y: int'(d1_pix_y), hs: int'(d1_hsync), vs: int'(d1_vsync),
              vo: int'(d1_video_on), pt: int'(d1_p_tick), rt: int'(d1_refr_tick)};
  end

  int n_cmp;
  int n_fail;
  int k;        // clock edges since reset was released
  int fc_sm;
  int fc_d1;
  int last_rt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish (k=%0d)", k);
    $fatal(1, "watchdog expired");
  end

  // Reference: position is simply the count of elapsed pixel periods since reset release.
  function automatic vga_t model(input int kk, input cfg_t c);
    vga_t e;
    int ht, vt, n;
    ht   = c.hd + c.hf + c.hr + c.hb;
    vt   = c.vd + c.vf + c.vr + c.vb;
    n    = (kk / c.d) % (ht * vt);
    e.x  = n % ht;
    e.y  = n / ht;
    e.pt = ((kk % c.d) == c.d - 1) ? 1 : 0;
    e.hs = (e.x >= c.hd + c.hf && e.x < c.hd + c.hf + c.hr) ? 0 : 1;
    e.vs = (e.y >= c.vd + c.vf && e.y < c.vd + c.vf + c.vr) ? 0 : 1;
    e.vo = (e.x < c.hd && e.y < c.vd) ? 1 : 0;
    e.rt = (e.pt == 1 && e.x == 0 && e.y == c.vd + 1) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, k);
    end
  endtask

  task automatic cmp(input string tag, input vga_t a, input vga_t e);
    check({tag, ".pix_x"},     a.x,  e.x);
    check({tag, ".pix_y"},     a.y,  e.y);
    check({tag, ".hsync"},     a.hs, e.hs);
    check({tag, ".vsync"},     a.vs, e.vs);
    check({tag, ".video_on"},  a.vo, e.vo);
    check({tag, ".p_tick"},    a.pt, e.pt);
    check({tag, ".refr_tick"}, a.rt, e.rt);
  endtask

  task automatic check_all();
    cmp("def", o_def, model(k, CFG_DEF));
    cmp("sm",  o_sm,  model(k, CFG_SM));
    cmp("d1",  o_d1,  model(k, CFG_D1));
`ifdef VGA_FRAME_CNT_EN
    check("sm.frame_cnt", int'(sm_frame_cnt), fc_sm);
    check("d1.frame_cnt", int'(d1_frame_cnt), fc_d1);
`endif
    if (o_sm.rt == 1) begin
      if (last_rt >= 0) check("sm.refr_period", k - last_rt, SM_FRAME_CLKS);
      last_rt = k;
    end
  endtask

  task automatic step();
    if (model(k, CFG_SM).rt == 1) fc_sm = (fc_sm + 1) % 256;
    if (model(k, CFG_D1).rt == 1) fc_d1 = (fc_d1 + 1) % 256;
    @(posedge clk);
    k++;
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous assertion between edges; outputs must be at reset values right away.
  task automatic do_reset(input int hold);
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    k = 0; fc_sm = 0; fc_d1 = 0; last_rt = -1;
    check_all();
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  vec_t tbl[10];
  vga_t m;
  int   idx, hs_low, vo_fall_x, guard;

  initial begin
    n_cmp = 0; n_fail = 0; k = 0; fc_sm = 0; fc_d1 = 0; last_rt = -1;
    rst_n = 1'b1;

    //            k     x    y  hs vs vo pt
    tbl[0] = '{   0,    0,  0, 1, 1, 1, 0};
    tbl[1] = '{   1,    0,  0, 1, 1, 1, 1};
    tbl[2] = '{   2,    1,  0, 1, 1, 1, 0};
    tbl[3] = '{1279,  639,  0, 1, 1, 1, 1};
    tbl[4] = '{1280,  640,  0, 1, 1, 0, 0};
    tbl[5] = '{1312,  656,  0, 0, 1, 0, 0};
    tbl[6] = '{1503,  751,  0, 0, 1, 0, 1};
    tbl[7] = '{1504,  752,  0, 1, 1, 0, 0};
    tbl[8] = '{1599,  799,  0, 1, 1, 0, 1};
    tbl[9] = '{1600,    0,  1, 1, 1, 1, 0};

    #1 rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;

    // One full default-timing line with table checkpoints.
    idx = 0; hs_low = 0; vo_fall_x = -1;
    while (1) begin
      if (o_def.hs == 0) hs_low++;
      if (vo_fall_x < 0 && o_def.vo == 0) vo_fall_x = o_def.x;
      if (idx < 10 && tbl[idx].k == k) begin
        check("tbl.pix_x",    o_def.x,  tbl[idx].x);
        check("tbl.pix_y",    o_def.y,  tbl[idx].y);
        check("tbl.hsync",    o_def.hs, tbl[idx].hs);
        check("tbl.vsync",    o_def.vs, tbl[idx].vs);
        check("tbl.video_on", o_def.vo, tbl[idx].vo);
        check("tbl.p_tick",   o_def.pt, tbl[idx].pt);
        idx++;
      end
      if (k == 1600) break;
      step();
    end
    check("line.tbl_rows",      idx,       10);
    check("line.hsync_low_clks", hs_low,   192);
    check("line.video_off_x",   vo_fall_x, 640);

    // Frame wrap on the reduced instance: (7,6) -> (0,0).
    guard = 0;
    m = model(k, CFG_SM);
    while (!(m.x == 7 && m.y == 6 && m.pt == 1) && guard < 400) begin
      step();
      guard++;
      m = model(k, CFG_SM);
    end
    check("wrap.reached", (guard < 400) ? 1 : 0, 1);
    step();
    check("wrap.pix_x",    o_sm.x,  0);
    check("wrap.pix_y",    o_sm.y,  0);
    check("wrap.video_on", o_sm.vo, 1);
    check("wrap.hsync",    o_sm.hs, 1);
    check("wrap.vsync",    o_sm.vs, 1);

    // Mid-frame reset and restart timing.
    guard = 0;
    m = model(k, CFG_SM);
    while (!(m.x == 2 && m.y == 1) && guard < 400) begin
      step();
      guard++;
      m = model(k, CFG_SM);
    end
    check("midrst.reached", (guard < 400) ? 1 : 0, 1);
    do_reset(3);
    step();
    check("restart.pix_x_1",  o_sm.x,  0);
    check("restart.p_tick_1", o_sm.pt, 1);
    step();
    check("restart.pix_x_2",  o_sm.x,  1);
    check("restart.p_tick_2", o_sm.pt, 0);
    check("restart.def_x_2",  o_def.x, 1);

    // Random run lengths separated by asynchronous resets at random phases.
    for (int s = 0; s < 8; s++) begin
      repeat ($urandom_range(20, 400)) step();
      do_reset($urandom_range(1, 5));
    end
    repeat (3 * SM_FRAME_CLKS) step();

`ifdef VGA_FRAME_CNT_EN
    // 257 refresh ticks: counter wraps through 255 -> 0 and reads 1.
    do_reset(2);
    while (k < 65 + 256 * SM_FRAME_CLKS + 1) step();
    check("frame_cnt.after_257", int'(sm_frame_cnt), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
